// File: rtl/bp_cfg_boot_loader.sv
// Boot-time configuration sequencer: freezes each core, programs its id and CCE mode,
// clears every LCE set, then unfreezes all cores and reports done.
module bp_cfg_boot_loader #(
   parameter int num_core_p       = 1,
   parameter int lce_sets_p       = 64,
   parameter int cfg_addr_width_p = 16,
   parameter int cfg_data_width_p = 32,
   localparam int core_w = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        start_i,
   output logic                        cfg_v_o,
   input  logic                        cfg_ready_i,
   output logic [core_w-1:0]           cfg_core_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   output logic                        done_o
);

   localparam int set_w = (lce_sets_p > 1) ? $clog2(lce_sets_p) : 1;

   localparam logic [core_w-1:0] last_core = core_w'(num_core_p - 1);
   localparam logic [set_w-1:0]  last_set  = set_w'(lce_sets_p - 1);

   localparam logic [cfg_addr_width_p-1:0] addr_freeze   = cfg_addr_width_p'(16'h0001);
   localparam logic [cfg_addr_width_p-1:0] addr_core_id  = cfg_addr_width_p'(16'h0002);
   localparam logic [cfg_addr_width_p-1:0] addr_cce_mode = cfg_addr_width_p'(16'h0003);
   localparam logic [cfg_addr_width_p-1:0] addr_clear    = cfg_addr_width_p'(16'h0010);

   typedef enum logic [2:0] {
      IDLE,
      FREEZE,
      CORE_ID,
      CCE_MODE,
      CLEAR,
      UNFREEZE,
      DONE
   } state_e;

   state_e             state, state_nxt;
   logic [core_w-1:0]  core_cnt, core_nxt;
   logic [set_w-1:0]   set_cnt, set_nxt;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state    <= IDLE;
         core_cnt <= '0;
         set_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         core_cnt <= core_nxt;
         set_cnt  <= set_nxt;
      end
   end

   // Outputs decode from registered state only, so the payload cannot move during a stall
   // and cfg_v_o never sees cfg_ready_i combinationally.
   always_comb begin
      state_nxt  = state;
      core_nxt   = core_cnt;
      set_nxt    = set_cnt;
      cfg_v_o    = 1'b0;
      done_o     = 1'b0;
      cfg_core_o = '0;
      cfg_addr_o = '0;
      cfg_data_o = '0;

      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = FREEZE;
               core_nxt  = '0;
               set_nxt   = '0;
            end
         end

         FREEZE: begin
            cfg_v_o    = 1'b1;
            cfg_core_o = core_cnt;
            cfg_addr_o = addr_freeze;
            cfg_data_o = cfg_data_width_p'(1);
            if (cfg_ready_i) state_nxt = CORE_ID;
         end

         CORE_ID: begin
            cfg_v_o    = 1'b1;
            cfg_core_o = core_cnt;
            cfg_addr_o = addr_core_id;
            cfg_data_o = cfg_data_width_p'(core_cnt);
            if (cfg_ready_i) state_nxt = CCE_MODE;
         end

         CCE_MODE: begin
            cfg_v_o    = 1'b1;
            cfg_core_o = core_cnt;
            cfg_addr_o = addr_cce_mode;
            cfg_data_o = cfg_data_width_p'(1);
            if (cfg_ready_i) state_nxt = CLEAR;
         end

         CLEAR: begin
            cfg_v_o    = 1'b1;
            cfg_core_o = core_cnt;
            cfg_addr_o = addr_clear;
            cfg_data_o = cfg_data_width_p'(set_cnt);
            if (cfg_ready_i) begin
               if (set_cnt == last_set) begin
                  set_nxt = '0;
                  if (core_cnt == last_core) begin
                     core_nxt  = '0;
                     state_nxt = UNFREEZE;
                  end else begin
                     core_nxt  = core_cnt + 1'b1;
                     state_nxt = FREEZE;
                  end
               end else begin
                  set_nxt = set_cnt + 1'b1;
               end
            end
         end

         UNFREEZE: begin
            cfg_v_o    = 1'b1;
            cfg_core_o = core_cnt;
            cfg_addr_o = addr_freeze;
            cfg_data_o = '0;
            if (cfg_ready_i) begin
               if (core_cnt == last_core) begin
                  core_nxt  = '0;
                  state_nxt = DONE;
               end else begin
                  core_nxt = core_cnt + 1'b1;
               end
            end
         end

         DONE: begin
            done_o = 1'b1;
            if (!start_i) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/bp_cfg_boot_loader.md
BP_CFG_BOOT_LOADER -- requirements
Module: bp_cfg_boot_loader

Interface
REQ-001 SHALL have parameter num_core_p, default 1, number of cores to configure (cc_x_dim*cc_y_dim of the selected config).
REQ-002 SHALL have parameter lce_sets_p, default 64, number of LCE sets to clear per core.
REQ-003 SHALL have parameter cfg_addr_width_p, default 16, config bus address width.
REQ-004 SHALL have parameter cfg_data_width_p, default 32, config bus data width.
REQ-005 SHALL have port clk_i input 1, the single clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port reset_n_i input 1, asynchronous active-low reset.
REQ-007 SHALL have port start_i input 1, level; a boot sequence begins on a cycle where start_i=1 in IDLE.
REQ-008 SHALL have port cfg_v_o output 1, config write valid.
REQ-009 SHALL have port cfg_ready_i input 1, config write accepted by the downstream bus.
REQ-010 SHALL have port cfg_core_o output clog2(num_core_p) (min 1), target core id.
REQ-011 SHALL have port cfg_addr_o output cfg_addr_width_p, config register address.
REQ-012 SHALL have port cfg_data_o output cfg_data_width_p, config write data.
REQ-013 SHALL have port done_o output 1, high while in DONE.

Function
REQ-014 SHALL implement states IDLE, FREEZE, CORE_ID, CCE_MODE, CLEAR, UNFREEZE, DONE.
REQ-015 SHALL advance out of any write state only on a cycle with cfg_v_o=1 and cfg_ready_i=1 (a "transfer").
REQ-016 SHALL hold cfg_core_o, cfg_addr_o and cfg_data_o stable while cfg_v_o=1 and cfg_ready_i=0.
REQ-017 SHALL drive cfg_v_o=1 in every write state and 0 in IDLE and DONE; cfg_v_o SHALL not depend combinationally on cfg_ready_i.
REQ-018 SHALL issue in FREEZE: addr 0x0001, data 1, core = current core counter.
REQ-019 SHALL issue in CORE_ID: addr 0x0002, data = core counter zero-extended.
REQ-020 SHALL issue in CCE_MODE: addr 0x0003, data 1 (normal mode).
REQ-021 SHALL issue in CLEAR: addr 0x0010, data = set counter zero-extended; set counter increments per transfer from 0 to lce_sets_p-1.
REQ-022 SHALL, on the CLEAR transfer with set counter = lce_sets_p-1, reset the set counter to 0 and go to FREEZE with core counter+1, or to UNFREEZE with core counter reset to 0 if core counter = num_core_p-1.
REQ-023 SHALL issue in UNFREEZE: addr 0x0001, data 0, core = core counter; increments per transfer; transfer at num_core_p-1 goes to DONE.
REQ-024 SHALL go IDLE->FREEZE (core 0, set 0) when start_i=1; one write is therefore issued per transfer with no idle bubble between consecutive writes when cfg_ready_i stays high.
REQ-025 SHALL leave DONE for IDLE when start_i=0, and remain in DONE while start_i=1 (no re-boot without a start_i low phase).
REQ-026 SHALL issue exactly num_core_p*(3+lce_sets_p)+num_core_p transfers per boot sequence.
REQ-027 SHALL treat num_core_p=1 correctly (counter width 1, wraps immediately).

Reset
REQ-028 SHALL, on reset_n_i=0 asynchronously and regardless of state, enter IDLE, clear core and set counters, and drive cfg_v_o=0, done_o=0, cfg_core_o=0, cfg_addr_o=0, cfg_data_o=0.
REQ-029 SHALL, when reset asserts mid-transfer, abandon the sequence; the next start_i restarts from core 0 FREEZE.
REQ-030 SHALL sample start_i only after reset_n_i deasserts; first FREEZE valid appears no earlier than the cycle after the first start_i=1 edge.

Verification
REQ-031 SHALL cover: num_core_p=1, lce_sets_p=4, cfg_ready_i=1, start_i=1 -> 8 consecutive transfers (1/1, 2/0, 3/1, 10/0..10/3, 1/0) then done_o=1.
REQ-032 SHALL cover: num_core_p=2, lce_sets_p=2, ready random 50% -> 12 transfers in order, payload stable during every stall, core field 0,0,0,0,0,1,1,1,1,1,0,1.
REQ-033 SHALL cover: cfg_ready_i=0 for 20 cycles in FREEZE -> cfg_v_o stays 1, addr 0x0001 data 1 unchanged, no state advance.
REQ-034 SHALL cover: reset_n_i pulsed low during CLEAR set 2 -> outputs zero immediately (same cycle, asynchronous); next start_i reissues core 0 FREEZE.
REQ-035 SHALL cover: start_i held high after DONE -> no further transfers; start_i low one cycle then high -> full sequence repeats.
